// File: rtl/file_regfile_mac_pkg.sv
// Shared definitions for the file_regfile_mac register file.
// Holds the {a,b} opcode encoding, the entry count and the address width.
package file_regfile_mac_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  // True for the operations that send a result down the return pipe.
  function automatic logic op_returns(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/file_regfile_mac_ret_pipe.sv
// file_ret_pipe: PAR-deep delay line carrying {valid, data, flag}.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/data/flag  result entering at the issue edge
//   out_valid           one-cycle strobe, PAR edges after entry (counting the entry edge)
//   out_data/out_flag   returned value; held while out_valid is low
module file_ret_pipe #(
  parameter int W   = 8,
  parameter int PAR = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_flag,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_flag
);

  logic [PAR-1:0] vld_q, vld_d;
  logic [PAR-1:0] flg_q, flg_d;
  logic [W-1:0]   dat_q [PAR];
  logic [W-1:0]   dat_d [PAR];

  // src_* is what feeds stage i: the input for stage 0, the previous stage otherwise.
  logic [PAR-1:0] src_v;
  logic [PAR-1:0] src_f;
  logic [W-1:0]   src_d [PAR];

  always_comb begin
    src_v[0] = in_valid;
    src_f[0] = in_flag;
    src_d[0] = in_data;
    for (int i = 1; i < PAR; i++) begin
      src_v[i] = vld_q[i-1];
      src_f[i] = flg_q[i-1];
      src_d[i] = dat_q[i-1];
    end

    for (int i = 0; i < PAR; i++) begin
      vld_d[i] = src_v[i];
      flg_d[i] = src_f[i];
      dat_d[i] = src_d[i];
    end

    // The last stage doubles as the output register, so it only takes
    // new data/flag when a valid result arrives; otherwise it holds.
    if (!src_v[PAR-1]) begin
      flg_d[PAR-1] = flg_q[PAR-1];
      dat_d[PAR-1] = dat_q[PAR-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      flg_q <= '0;
      for (int i = 0; i < PAR; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      flg_q <= flg_d;
      for (int i = 0; i < PAR; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign out_valid = vld_q[PAR-1];
  assign out_data  = dat_q[PAR-1];
  assign out_flag  = flg_q[PAR-1];

endmodule

// File: rtl/file_regfile_mac.sv
// file_regfile_mac: 32 x WIDTH register file with in-place multiply-update
// and a fixed-latency read-return pipe.
// Ports:
//   clk, rst   clock, async active-high reset
//   data_in    write data / multiplier operand
//   a, b       opcode {a,b}: 00 idle, 10 write, 01 read, 11 multiply-update
//   x          entry address
//   data_out   returned entry value (held between results)
//   out        overflow flag of the returned result
//   d          result-valid pulse, par edges after issue (issue edge included)
module file_regfile_mac
  import file_regfile_mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int par       = 3,
  parameter int MUL_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              a,
  input  logic              b,
  input  logic [ADDR_W-1:0] x,
  output logic [WIDTH-1:0]  data_out,
  output logic              out,
  output logic              d
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [1:0]           op;
  logic [MUL_WIDTH-1:0] prod;
  logic                 iss_valid;
  logic [WIDTH-1:0]     iss_data;
  logic                 iss_ovf;

  assign op   = {a, b};
  assign prod = MUL_WIDTH'(mem_q[x]) * MUL_WIDTH'(data_in);

  always_comb begin
    mem_d     = mem_q;
    iss_valid = op_returns(op);
    iss_data  = '0;
    iss_ovf   = 1'b0;
    case (op)
      OP_WRITE: mem_d[x] = data_in;
      OP_READ:  iss_data = mem_q[x];
      OP_MUL: begin
        mem_d[x] = prod[WIDTH-1:0];
        iss_data = prod[WIDTH-1:0];
        iss_ovf  = |prod[MUL_WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  file_ret_pipe #(
    .W   (WIDTH),
    .PAR (par)
  ) u_ret_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iss_valid),
    .in_data   (iss_data),
    .in_flag   (iss_ovf),
    .out_valid (d),
    .out_data  (data_out),
    .out_flag  (out)
  );

endmodule

// File: tb/tb_file_regfile_mac.sv
module tb_file_regfile_mac;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       a;
  logic       b;
  logic [4:0] x;
  logic [7:0] data_out;
  logic       out;
  logic       d;

  int total;
  int bad;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RD   = 2'b01;
  localparam logic [1:0] WR   = 2'b10;
  localparam logic [1:0] MUL  = 2'b11;

  file_regfile_mac #(.WIDTH(8), .par(3), .MUL_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .a        (a),
    .b        (b),
    .x        (x),
    .data_out (data_out),
    .out      (out),
    .d        (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one op, let one edge take it, return 1 time unit after that edge.
  task automatic op_cyc(input logic [1:0] o, input logic [4:0] addr, input logic [7:0] din);
    {a, b}  = o;
    x       = addr;
    data_in = din;
    @(posedge clk);
    #1;
    {a, b}  = IDLE;
  endtask

  task automatic chk_out(input string tag, input logic exp_d, input logic [7:0] exp_data,
                         input logic exp_ovf);
    chk({tag, "_d"}, 32'(d), 32'(exp_d));
    chk({tag, "_data"}, 32'(data_out), 32'(exp_data));
    chk({tag, "_ovf"}, 32'(out), 32'(exp_ovf));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    {a, b}  = IDLE;
    x       = '0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // write/read latency: result only after the second edge following issue
    op_cyc(WR, 5'd7, 8'hA5);
    op_cyc(RD, 5'd7, 8'h00);
    chk("lat_k_d", 32'(d), 32'd0);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk("lat_k1_d", 32'(d), 32'd0);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("lat_k2", 1'b1, 8'hA5, 1'b0);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("lat_hold", 1'b0, 8'hA5, 1'b0);

    // multiply, no overflow: 12*10 = 120
    op_cyc(WR, 5'd3, 8'd12);
    op_cyc(MUL, 5'd3, 8'd10);
    op_cyc(IDLE, 5'd0, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("mul", 1'b1, 8'd120, 1'b0);
    op_cyc(RD, 5'd3, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("mul_rd", 1'b1, 8'd120, 1'b0);

    // multiply with overflow: 200*3 = 600 = 16'h0258
    op_cyc(WR, 5'd4, 8'd200);
    op_cyc(MUL, 5'd4, 8'd3);
    op_cyc(IDLE, 5'd0, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("mul_ovf", 1'b1, 8'h58, 1'b1);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("ovf_hold", 1'b0, 8'h58, 1'b1);
    op_cyc(RD, 5'd4, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("ovf_rd", 1'b1, 8'h58, 1'b0);

    // writes and idles: no pulse, outputs hold 8'h58 / 0
    for (int i = 0; i < 32; i++) begin
      op_cyc(WR, 5'(i), 8'(i));
      chk_out("wr_hold", 1'b0, 8'h58, 1'b0);
    end
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("idle_hold", 1'b0, 8'h58, 1'b0);

    // 32 back-to-back reads: pulse every edge from the third onward
    for (int i = 0; i < 34; i++) begin
      if (i < 32) op_cyc(RD, 5'(i), 8'h00);
      else        op_cyc(IDLE, 5'd0, 8'h00);
      if (i >= 2) chk_out("b2b", 1'b1, 8'(i - 2), 1'b0);
      else        chk("b2b_pre_d", 32'(d), 32'd0);
    end
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("b2b_end", 1'b0, 8'd31, 1'b0);

    // read on the edge right after a write sees the new value
    op_cyc(WR, 5'd9, 8'h3C);
    op_cyc(RD, 5'd9, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("raw", 1'b1, 8'h3C, 1'b0);

    // reset with reads in flight; write attempted during reset is ignored
    op_cyc(RD, 5'd5, 8'h00);
    op_cyc(RD, 5'd6, 8'h00);
    rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 8'h00, 1'b0);
    {a, b}  = WR;
    x       = 5'd5;
    data_in = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    {a, b} = IDLE;
    rst    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_cyc(IDLE, 5'd0, 8'h00);
      chk_out("rst_nopulse", 1'b0, 8'h00, 1'b0);
    end
    op_cyc(RD, 5'd5, 8'h00);
    op_cyc(RD, 5'd31, 8'h00);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("rst_rd5", 1'b1, 8'h00, 1'b0);
    op_cyc(IDLE, 5'd0, 8'h00);
    chk_out("rst_rd31", 1'b1, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
